// File: rtl/timer_core.sv
// Start/stop interval timer: counts synchronized ps_clk rising edges between
// a start strobe and a stop strobe and publishes the saturated count.
module timer_core #(
    parameter int unsigned TIMER_COUNTER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ps_clk,
    input  logic                           enable_signal,
    input  logic                           final_signal,
    output logic [TIMER_COUNTER_WIDTH-1:0] counter_result
);

    localparam int unsigned W = TIMER_COUNTER_WIDTH;
    localparam logic [W-1:0] C_MAX = {W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_sync3;
    logic           w_tick;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_nxt;
    logic [W-1:0]   r_result;
    logic [W-1:0]   w_result_nxt;
    logic [W-1:0]   w_count_inc;

    // ps_clk is asynchronous data: two flops for metastability, third for edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= ps_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_tick      = r_sync2 & ~r_sync3;
    assign w_count_inc = (r_count == C_MAX) ? C_MAX : r_count + W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Stop cycle still counts its own tick, so the window is (start, stop]
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_result_nxt = r_result;
        case (r_state)
            IDLE: begin
                if (enable_signal) begin
                    w_count_nxt = '0;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (final_signal) begin
                    w_result_nxt = w_tick ? w_count_inc : r_count;
                    w_state_nxt  = IDLE;
                end else if (w_tick) begin
                    w_count_nxt = w_count_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign counter_result = r_result;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: a 16-bit instance for function/reset checks
// and a 4-bit instance for saturation.
module tb_timer_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps_clk_a = 1'b0;
    logic        ps_clk_b = 1'b0;
    logic        en_a = 1'b0;
    logic        fin_a = 1'b0;
    logic        en_b = 1'b0;
    logic        fin_b = 1'b0;
    logic [15:0] res_a;
    logic [3:0]  res_b;

    int ps_half_a = 2;
    int checks    = 0;
    int failures  = 0;

    timer_core #(.TIMER_COUNTER_WIDTH(16)) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .ps_clk         (ps_clk_a),
        .enable_signal  (en_a),
        .final_signal   (fin_a),
        .counter_result (res_a)
    );

    timer_core #(.TIMER_COUNTER_WIDTH(4)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .ps_clk         (ps_clk_b),
        .enable_signal  (en_b),
        .final_signal   (fin_b),
        .counter_result (res_b)
    );

    initial forever #5 clk = ~clk;

    // Time base for A: half-period in clk cycles, 0 holds ps_clk high
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ps_half_a == 0) begin
                ps_clk_a = 1'b1;
            end else begin
                ph++;
                if (ph >= ps_half_a) begin
                    ph = 0;
                    ps_clk_a = ~ps_clk_a;
                end
            end
        end
    end

    // Time base for B: fixed period of 2 clk cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ps_clk_b = ~ps_clk_b;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_strobes(input bit sel, input logic en, input logic fin);
        if (sel) begin
            en_b = en;
            fin_b = fin;
        end else begin
            en_a = en;
            fin_a = fin;
        end
    endtask

    // Start at edge E, optional re-trigger at E+retrig, stop at E+gap; returns just after stop edge
    task automatic run_meas(input bit sel, input int gap, input int retrig);
        set_strobes(sel, 1'b1, 1'b0);
        step(1);
        for (int i = 1; i < gap; i++) begin
            set_strobes(sel, (i == retrig) ? 1'b1 : 1'b0, 1'b0);
            step(1);
        end
        set_strobes(sel, 1'b0, 1'b1);
        step(1);
        set_strobes(sel, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit          sel;
        int          ps_half;
        int          gap;
        int          retrig;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [15:0] res_of(input bit sel);
        return sel ? {12'd0, res_b} : res_a;
    endfunction

    initial begin
        vecs[0] = '{1'b0, 2,  40,  0, 16'd10};
        vecs[1] = '{1'b0, 2,  40, 20, 16'd10};
        vecs[2] = '{1'b0, 2,  20,  0, 16'd5};
        vecs[3] = '{1'b0, 2,   8,  0, 16'd2};
        vecs[4] = '{1'b0, 1,  40,  0, 16'd20};
        vecs[5] = '{1'b0, 0, 100,  0, 16'd0};
        vecs[6] = '{1'b0, 2, 400,  0, 16'd100};
        vecs[7] = '{1'b1, 1,  20,  0, 16'd10};
        vecs[8] = '{1'b1, 1,  30,  0, 16'd15};
        vecs[9] = '{1'b1, 1, 100,  0, 16'd15};

        // Reset values
        step(3);
        check("reset_a", res_a, 16'd0);
        check("reset_b", res_of(1'b1), 16'd0);
        rst = 1'b0;
        step(10);

        foreach (vecs[k]) begin
            if (!vecs[k].sel) ps_half_a = vecs[k].ps_half;
            step(10);
            run_meas(vecs[k].sel, vecs[k].gap, vecs[k].retrig);
            check($sformatf("vec%0d", k), res_of(vecs[k].sel), vecs[k].exp);
            step(5);
            check($sformatf("vec%0d_hold", k), res_of(vecs[k].sel), vecs[k].exp);
        end

        // Width-4 window of exactly 16 ticks must clamp, not wrap to 0
        step(5);
        run_meas(1'b1, 32, 0);
        check("sat_16_ticks", res_of(1'b1), 16'd15);

        // Stop strobe alone in IDLE leaves the result alone
        ps_half_a = 2;
        step(10);
        run_meas(1'b0, 20, 0);
        check("pre_idle_final", res_a, 16'd5);
        fin_a = 1'b1;
        step(1);
        fin_a = 1'b0;
        step(3);
        check("idle_final_ignored", res_a, 16'd5);

        // Coincident strobes: start from IDLE, stop from COUNT
        en_a = 1'b1; fin_a = 1'b1; step(1); en_a = 1'b0; fin_a = 1'b0;
        step(39);
        en_a = 1'b1; fin_a = 1'b1; step(1); en_a = 1'b0; fin_a = 1'b0;
        check("period_first", res_a, 16'd10);
        step(19);
        fin_a = 1'b1; step(1); fin_a = 1'b0;
        check("period_no_restart", res_a, 16'd10);
        step(9);
        en_a = 1'b1; fin_a = 1'b1; step(1); en_a = 1'b0; fin_a = 1'b0;
        check("period_restart_no_store", res_a, 16'd10);
        step(19);
        en_a = 1'b1; fin_a = 1'b1; step(1); en_a = 1'b0; fin_a = 1'b0;
        check("period_second", res_a, 16'd5);

        // Reset mid-measurement aborts it; later stop is ignored
        step(5);
        en_a = 1'b1; step(1); en_a = 1'b0;
        step(19);
        rst = 1'b1; step(1); rst = 1'b0;
        check("rst_mid_count", res_a, 16'd0);
        step(19);
        fin_a = 1'b1; step(1); fin_a = 1'b0;
        check("rst_final_ignored", res_a, 16'd0);
        step(10);
        run_meas(1'b0, 40, 0);
        check("after_rst_meas", res_a, 16'd10);

        // Reset wins over a simultaneous start strobe
        step(5);
        rst = 1'b1; en_a = 1'b1; step(1); rst = 1'b0; en_a = 1'b0;
        check("rst_with_enable", res_a, 16'd0);
        step(39);
        fin_a = 1'b1; step(1); fin_a = 1'b0;
        check("rst_priority", res_a, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
